// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential divide controller.
//   div_state_t       - controller state encoding (legacy 3-bit codes)
//   DIV_WIDTH_DEFAULT - default operand/result width
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 64;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring divide step.
//   rem      in  WIDTH+1  partial remainder before the shift
//   dvd_msb  in  1        dividend bit shifted into the remainder
//   dsr_mag  in  WIDTH    divisor magnitude
//   rem_next out WIDTH+1  partial remainder after the step
//   q_bit    out 1        quotient bit produced by this step
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] dsr_mag,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    // One extra bit of headroom so the trial sign is exact for any shifted value.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    always_comb begin
        shifted  = {rem, dvd_msb};
        trial    = shifted - {2'b00, dsr_mag};
        q_bit    = ~trial[WIDTH+1];
        rem_next = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle signed divider (restoring, one bit per cycle).
//   clk, rst_n           clock and synchronous active-low reset
//   flush                synchronous abort back to IDLE
//   start_valid/ready    operand handshake (a = dividend, b = divisor)
//   res_valid/ready      result handshake
//   q, r                 quotient (toward zero), remainder (sign of dividend)
//   div_by_zero          result came from b == 0
//   busy                 controller is not IDLE
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [WIDTH-1:0] q,
    output logic signed [WIDTH-1:0] r,
    output logic                    div_by_zero,
    output logic                    busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t       state;
    logic [WIDTH-1:0] dvd;      // operand a, then |a|, then the quotient as it shifts in
    logic [WIDTH-1:0] dsr;      // operand b, then |b|
    logic [WIDTH:0]   rem;
    logic [CNT_W-1:0] cnt;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH:0]   rem_next;
    logic             q_bit;

    // Two's-complement magnitude; the most-negative value maps to 2^(W-1) unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    // Conditional negate, wrapping modulo 2^W.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .dvd_msb  (dvd[WIDTH-1]),
        .dsr_mag  (dsr),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign start_ready = (state == IDLE);
    assign res_valid   = (state == DONE);
    assign busy        = (state != IDLE);

    // Control and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        if (b == '0) begin
                            q           <= '0;
                            r           <= '0;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= PREP;
                        end
                    end
                end
                PREP: state <= ITER;
                ITER: begin
                    if (cnt == LAST_STEP) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    q           <= cond_neg(dvd, neg_q);
                    r           <= cond_neg(rem[WIDTH-1:0], neg_r);
                    div_by_zero <= 1'b0;
                    state       <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath registers: loaded by state, no reset needed
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start_valid) begin
                    dvd   <= a;
                    dsr   <= b;
                    neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                    neg_r <= a[WIDTH-1];
                end
            end
            PREP: begin
                dvd <= mag(dvd);
                dsr <= mag(dsr);
                rem <= '0;
                cnt <= '0;
            end
            ITER: begin
                rem <= rem_next;
                dvd <= {dvd[WIDTH-2:0], q_bit};
                cnt <= cnt + 1'b1;
            end
            default: ;
        endcase
    end

endmodule
